// File: rtl/sound_arbiter.sv
// sound_arbiter: shares the single note-playing engine (Sound) between NREQ
// requesters (index 0 = live keyboard). Round-robin grant, fields latched at
// grant, completion tracked through snd_over, silent gap before re-arbitration.
// Optional feature macro: PREEMPT_EN -- when defined, requester 0 preempts any
// other owner while its note is armed or playing.
module sound_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned OCT_W   = 3,
    parameter int unsigned NOTE_W  = 3,
    parameter int unsigned LEN_W   = 3,
    parameter int unsigned GAP_CYC = 100000,
    parameter int unsigned ARM_TO  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*OCT_W-1:0]    req_oct,
    input  logic [NREQ*NOTE_W-1:0]   req_note,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     aborted,
    output logic                     snd_start,
    output logic [OCT_W-1:0]         snd_oct,
    output logic [NOTE_W-1:0]        snd_note,
    output logic [LEN_W-1:0]         snd_len,
    input  logic                     snd_over,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned ARM_W = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;
    // Counters run 0 .. LAST; a zero gap behaves like a one-cycle gap
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
    localparam logic [ARM_W-1:0] ARM_LAST = (ARM_TO > 0) ? ARM_W'(ARM_TO - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARMED = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [NREQ-1:0]     gnt_r, gnt_s;
    logic [NREQ-1:0]     done_r, done_s;
    logic                aborted_r, aborted_s;
    logic                start_r, start_s;
    logic [OCT_W-1:0]    oct_r, oct_s;
    logic [NOTE_W-1:0]   note_r, note_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic                busy_r, busy_s;
    logic [IDX_W-1:0]    last_r, last_s;
    logic [IDX_W-1:0]    owner_r, owner_s;
    logic [ARM_W-1:0]    arm_cnt_r, arm_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;

    logic [IDX_W:0]      cand_s;
    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                preempt_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin scan: first set request after the last winner, wrapping
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = last_r;
        cand_s      = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand_s = {1'b0, last_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NREQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

`ifdef PREEMPT_EN
    // Keyboard (requester 0) takes over an armed or playing note of another owner
    always_comb begin
        if ((state_r == ST_ARMED || state_r == ST_PLAY) && owner_r != '0 && req[0]) begin
            preempt_s = 1'b1;
        end else begin
            preempt_s = 1'b0;
        end
    end
`else
    // Without preemption the keyboard queues like any other requester
    always_comb begin
        preempt_s = 1'b0;
    end
`endif

    // Next-state and next-output logic; enable low overrides everything
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        done_s    = '0;
        aborted_s = 1'b0;
        start_s   = 1'b0;
        oct_s     = oct_r;
        note_s    = note_r;
        len_s     = len_r;
        last_s    = last_r;
        owner_s   = owner_r;
        arm_cnt_s = arm_cnt_r;
        gap_cnt_s = gap_cnt_r;
        if (!en) begin
            state_s = ST_IDLE;
            gnt_s   = '0;
        end else if (preempt_s) begin
            done_s    = onehot(owner_r);
            aborted_s = 1'b1;
            gnt_s     = onehot('0);
            oct_s     = req_oct[OCT_W-1:0];
            note_s    = req_note[NOTE_W-1:0];
            len_s     = req_len[LEN_W-1:0];
            last_s    = '0;
            owner_s   = '0;
            state_s   = ST_START;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        gnt_s   = onehot(win_idx_s);
                        oct_s   = req_oct[win_idx_s * OCT_W +: OCT_W];
                        note_s  = req_note[win_idx_s * NOTE_W +: NOTE_W];
                        len_s   = req_len[win_idx_s * LEN_W +: LEN_W];
                        last_s  = win_idx_s;
                        owner_s = win_idx_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    start_s   = 1'b1;
                    arm_cnt_s = '0;
                    state_s   = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!snd_over) begin
                        state_s = ST_PLAY;
                    end else if (arm_cnt_r == ARM_LAST) begin
                        // Engine never started: treat as a zero-length note
                        done_s    = onehot(owner_r);
                        gnt_s     = '0;
                        gap_cnt_s = '0;
                        state_s   = ST_GAP;
                    end else begin
                        arm_cnt_s = arm_cnt_r + ARM_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (snd_over) begin
                        done_s    = onehot(owner_r);
                        gnt_s     = '0;
                        gap_cnt_s = '0;
                        state_s   = ST_GAP;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    gnt_s   = '0;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, round-robin pointer, owner and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r     <= '0;
            done_r    <= '0;
            aborted_r <= 1'b0;
            start_r   <= 1'b0;
            oct_r     <= '0;
            note_r    <= '0;
            len_r     <= '0;
            busy_r    <= 1'b0;
            last_r    <= LAST_RST;
            owner_r   <= '0;
            arm_cnt_r <= '0;
            gap_cnt_r <= '0;
        end else begin
            gnt_r     <= gnt_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
            start_r   <= start_s;
            oct_r     <= oct_s;
            note_r    <= note_s;
            len_r     <= len_s;
            busy_r    <= busy_s;
            last_r    <= last_s;
            owner_r   <= owner_s;
            arm_cnt_r <= arm_cnt_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign snd_start = start_r;
    assign snd_oct   = oct_r;
    assign snd_note  = note_r;
    assign snd_len   = len_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter (GAP_CYC=4, ARM_TO=8) with a Sound model:
// over falls one cycle after start and rises after len*4 further cycles.
module tb_sound_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [2:0] req = 3'b111;
    logic [8:0] req_oct  = 9'o000;
    logic [8:0] req_note = 9'o000;
    logic [8:0] req_len  = 9'o000;
    logic [2:0] gnt, done;
    logic       aborted, snd_start, busy;
    logic [2:0] snd_oct, snd_note, snd_len;
    logic       snd_over;
    logic       dead = 1'b0;
    int unsigned snd_cnt;

    int checks   = 0;
    int failures = 0;

    sound_arbiter #(
        .NREQ(3), .OCT_W(3), .NOTE_W(3), .LEN_W(3), .GAP_CYC(4), .ARM_TO(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .req_oct(req_oct), .req_note(req_note), .req_len(req_len),
        .gnt(gnt), .done(done), .aborted(aborted), .snd_start(snd_start),
        .snd_oct(snd_oct), .snd_note(snd_note), .snd_len(snd_len),
        .snd_over(snd_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Sound engine model; 'dead' makes it ignore start and never drop over
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_over <= 1'b1;
            snd_cnt  <= 0;
        end else if (snd_start && !dead) begin
            snd_over <= 1'b0;
            snd_cnt  <= 4 * snd_len;
        end else if (!snd_over) begin
            if (snd_cnt == 0) snd_over <= 1'b1;
            else              snd_cnt  <= snd_cnt - 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin tick(); n++; end while (gnt == 3'b000 && n < 100);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin tick(); n++; end while (done == 3'b000 && n < 100);
    endtask

    // Round-robin reference: first requester after 'last', wrapping
    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    typedef struct {
        logic [2:0] req;
        logic [8:0] oct;
        logic [8:0] note;
        logic [8:0] len;
        logic [2:0] exp_gnt;
        logic [2:0] exp_oct;
        logic [2:0] exp_note;
        logic [2:0] exp_len;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, m_last, idx, lat;
        logic [2:0] e_oct, e_note, e_len;

        // pointer starts at 0 after the reset-sequence grant to requester 0
        tbl[0] = '{3'b110, 9'o123, 9'o704, 9'o120, 3'b010, 3'd2, 3'd0, 3'd2};
        tbl[1] = '{3'b110, 9'o765, 9'o321, 9'o102, 3'b100, 3'd7, 3'd3, 3'd1};
        tbl[2] = '{3'b110, 9'o017, 9'o250, 9'o011, 3'b010, 3'd1, 3'd5, 3'd1};
        tbl[3] = '{3'b101, 9'o444, 9'o617, 9'o201, 3'b100, 3'd4, 3'd6, 3'd2};
        tbl[4] = '{3'b011, 9'o356, 9'o123, 9'o210, 3'b001, 3'd6, 3'd3, 3'd0};
        tbl[5] = '{3'b111, 9'o273, 9'o561, 9'o121, 3'b010, 3'd7, 3'd6, 3'd2};
        tbl[6] = '{3'b001, 9'o005, 9'o007, 9'o001, 3'b001, 3'd5, 3'd7, 3'd1};
        tbl[7] = '{3'b100, 9'o300, 9'o400, 9'o200, 3'b100, 3'd3, 3'd4, 3'd2};

        // Reset held with all requesting
        repeat (3) tick();
        check("rst_gnt", gnt, 3'b000);
        check("rst_done", done, 3'b000);
        check("rst_aborted", aborted, 1'b0);
        check("rst_start", snd_start, 1'b0);
        check("rst_fields", {snd_oct, snd_note, snd_len}, 9'o000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("first_gnt", gnt, 3'b001);
        check("first_start_lo", snd_start, 1'b0);
        tick();
        check("first_start_hi", snd_start, 1'b1);
        tick();
        check("start_one_cycle", snd_start, 1'b0);
        wait_done(n);
        check("first_done", done, 3'b001);

        // Table-driven grants
        m_last = 0;
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; req_oct = tbl[i].oct; req_note = tbl[i].note; req_len = tbl[i].len;
            tick();
            check($sformatf("tbl%0d_done_pulse", i), done, 3'b000);
            wait_gnt(n);
            check($sformatf("tbl%0d_gap", i), n, 4);
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
            check($sformatf("tbl%0d_fields", i), {snd_oct, snd_note, snd_len},
                  {tbl[i].exp_oct, tbl[i].exp_note, tbl[i].exp_len});
            wait_done(n);
            check($sformatf("tbl%0d_lat", i), n, 4 * tbl[i].exp_len + 4);
            check($sformatf("tbl%0d_done", i), done, tbl[i].exp_gnt);
            check($sformatf("tbl%0d_aborted", i), aborted, 1'b0);
            m_last = (tbl[i].exp_gnt == 3'b001) ? 0 : (tbl[i].exp_gnt == 3'b010) ? 1 : 2;
        end

        // Randomized notes against the round-robin / timing model
        for (int r = 0; r < 40; r++) begin
            req      = 3'($urandom_range(7, 1));
            req_oct  = 9'($urandom);
            req_note = 9'($urandom);
            req_len  = 9'($urandom);
            dead     = ($urandom_range(4, 0) == 0);
            idx    = rr_pick(req, m_last);
            e_oct  = 3'((req_oct  >> (3 * idx)) & 9'd7);
            e_note = 3'((req_note >> (3 * idx)) & 9'd7);
            e_len  = 3'((req_len  >> (3 * idx)) & 9'd7);
            lat    = dead ? 9 : (4 * e_len + 4);
            tick();
            check("rnd_done_pulse", done, 3'b000);
            wait_gnt(n);
            check("rnd_gap", n, 4);
            check("rnd_gnt", gnt, 3'b001 << idx);
            check("rnd_fields", {snd_oct, snd_note, snd_len}, {e_oct, e_note, e_len});
            m_last = idx;
            wait_done(n);
            check("rnd_lat", n, lat);
            check("rnd_done", done, 3'b001 << idx);
            check("rnd_aborted", aborted, 1'b0);
        end
        dead = 1'b0;

        // Fields latched at grant; later changes ignored
        req = 3'b010; req_oct = 9'o040; req_note = 9'o050; req_len = 9'o020;
        tick();
        wait_gnt(n);
        check("latch_gnt", gnt, 3'b010);
        check("latch_note", snd_note, 3'd5);
        check("latch_oct", snd_oct, 3'd4);
        req_note = 9'o010;
        wait_done(n);
        check("latch_lat", n, 12);
        check("latch_note_done", snd_note, 3'd5);
        tick();
        check("latch_note_gap", snd_note, 3'd5);
        wait_gnt(n);
        check("latch_regap", n, 4);
        check("latch_note_new", snd_note, 3'd1);
        wait_done(n);

        // Engine never drops over: arm timeout
        dead = 1'b1;
        req = 3'b010;
        tick();
        wait_gnt(n);
        tick();
        check("to_start", snd_start, 1'b1);
        wait_done(n);
        check("to_lat", n, 8);
        check("to_done", done, 3'b010);
        check("to_aborted", aborted, 1'b0);
        dead = 1'b0;

        // Enable drop mid-note
        req = 3'b001; req_len = 9'o003;
        tick();
        wait_gnt(n);
        check("en_gnt", gnt, 3'b001);
        repeat (4) tick();
        en = 1'b0;
        tick();
        check("en_gnt_off", gnt, 3'b000);
        check("en_done_off", done, 3'b000);
        check("en_busy_off", busy, 1'b0);
        check("en_aborted_off", aborted, 1'b0);
        en = 1'b1;
        tick();
        check("en_regrant", gnt, 3'b001);
        tick();
        check("en_restart", snd_start, 1'b1);
        wait_done(n);
        check("en_done", done, 3'b001);

        // Keyboard request while owner 2 plays
        req = 3'b100; req_len = 9'o300; req_note = 9'o200; req_oct = 9'o000;
        tick();
        wait_gnt(n);
        check("pre_gnt", gnt, 3'b100);
        repeat (4) tick();
        req = 3'b101; req_note = 9'o206; req_len = 9'o301;
        tick();
`ifdef PREEMPT_EN
        check("pre_done", done, 3'b100);
        check("pre_aborted", aborted, 1'b1);
        check("pre_gnt0", gnt, 3'b001);
        check("pre_note", snd_note, 3'd6);
        tick();
        check("pre_start", snd_start, 1'b1);
        wait_done(n);
        check("pre_done0", done, 3'b001);
`else
        check("nopre_gnt", gnt, 3'b100);
        check("nopre_done", done, 3'b000);
        wait_done(n);
        check("nopre_done2", done, 3'b100);
        check("nopre_aborted", aborted, 1'b0);
        tick();
        wait_gnt(n);
        check("nopre_gap", n, 4);
        check("nopre_gnt0", gnt, 3'b001);
        wait_done(n);
        check("nopre_done0", done, 3'b001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
